btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter NUM_BTN, default 3, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 240000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz).
REQ-003 Parameter HOLD_CYCLES, default 12000000, cycles a channel must stay pressed before a hold pulse (1 s at 12 MHz).
REQ-004 Parameter ACTIVE_LOW, default 0; 1 means a raw input of 0 is "pressed".
REQ-005 CLK  input  1  single system clock; all logic rising-edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 BTN  input  NUM_BTN  raw asynchronous button inputs.
REQ-008 BTN_LEVEL  output  NUM_BTN  debounced level, 1 = pressed.
REQ-009 BTN_PRESS  output  NUM_BTN  one-cycle pulse on accepted press.
REQ-010 BTN_RELEASE  output  NUM_BTN  one-cycle pulse on accepted release.
REQ-011 BTN_HOLD  output  NUM_BTN  one-cycle pulse when HOLD_CYCLES have elapsed since an accepted press.

Function
REQ-012 Each BTN bit SHALL pass a 2-flop synchronizer, then polarity correction per ACTIVE_LOW, before any other logic.
REQ-013 Each channel SHALL run an independent FSM: UP, CONFIRM_DOWN, DOWN, CONFIRM_UP.
REQ-014 UP -> CONFIRM_DOWN when synced pressed = 1; counter cleared on entry.
REQ-015 CONFIRM_DOWN: counter increments each cycle pressed = 1; pressed = 0 returns to UP with no output activity.
REQ-016 CONFIRM_DOWN -> DOWN on the cycle the counter reaches DEBOUNCE_CYCLES-1 with pressed = 1; BTN_PRESS high that cycle only; BTN_LEVEL = 1 from the following cycle.
REQ-017 DOWN -> CONFIRM_UP when pressed = 0; CONFIRM_UP symmetric to CONFIRM_DOWN, returning to DOWN on a glitch and to UP with one BTN_RELEASE pulse after DEBOUNCE_CYCLES.
REQ-018 Latency from a clean raw edge to the PRESS/RELEASE pulse SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-019 A hold counter SHALL start at the accepted press, keep counting through CONFIRM_UP glitches, and pulse BTN_HOLD once when it reaches HOLD_CYCLES-1; it SHALL saturate, with no further HOLD pulses until the next accepted press.
REQ-020 An accepted release before HOLD_CYCLES SHALL clear the hold counter with no HOLD pulse.
REQ-021 Counter widths SHALL be $clog2 of the respective parameter, minimum 1 bit; no counter wraps.
REQ-022 Channels pressed simultaneously SHALL produce simultaneous, independent pulses.
REQ-023 PRESS, RELEASE and HOLD SHALL be registered outputs, never combinational from BTN.

Reset
REQ-024 While RST_N = 0: all FSMs in UP, all counters and synchronizer flops 0 (released), all outputs 0.
REQ-025 A button held during reset release SHALL be treated as a new press: BTN_PRESS DEBOUNCE_CYCLES+2 cycles after RST_N rises.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL abort without emitting any pulse.

Structure
REQ-027 FSM state encoding SHALL live in shared package btn_pkg; timing defaults belong beside it as localparams.
REQ-028 One sub-module btn_debounce_ch (synchronizer, FSM, both counters) SHALL be instantiated NUM_BTN times via generate.

Verification (DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, ACTIVE_LOW=0)
REQ-029 Clean press at cycle 0 -> BTN_PRESS[0] high at cycle 10 only, BTN_LEVEL[0]=1 from cycle 11.
REQ-030 Raw BTN[1] pulses 1 for 5 cycles -> no PRESS, LEVEL stays 0.
REQ-031 Press held 40 cycles -> exactly one BTN_HOLD pulse 32 cycles after PRESS; release -> RELEASE 10 cycles after raw fall, no extra HOLD.
REQ-032 All three buttons pressed same cycle -> PRESS=3'b111 on the same cycle.
REQ-033 Reset asserted 4 cycles after a press, released with button still high -> no pulses during reset, PRESS 10 cycles after RST_N rises.
REQ-034 3-cycle dropout during DOWN -> no RELEASE, LEVEL remains 1, HOLD timing unaffected.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: per-channel FSM encoding and timing defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    ST_UP           = 2'd0,
    ST_CONFIRM_DOWN = 2'd1,
    ST_DOWN         = 2'd2,
    ST_CONFIRM_UP   = 2'd3
  } btn_state_e;

  // Defaults for a 12 MHz system clock: 20 ms debounce, 1 s hold.
  localparam int          DEF_NUM_BTN         = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;
  localparam int unsigned DEF_HOLD_CYCLES     = 12000000;
  localparam bit          DEF_ACTIVE_LOW      = 1'b0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, polarity fix, debounce FSM, hold timer.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 cycles after a clean raw edge; level one cycle after the pulse.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   btn_i      raw asynchronous button input
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse on accepted press
//   release_o  one-cycle pulse on accepted release
//   hold_o     one-cycle pulse HOLD_CYCLES after an accepted press
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned      DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned      HD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0]  HD_LAST = HD_W'(HOLD_CYCLES - 1);
  // Raw level that means "released"; the synchronizer resets to it so that
  // a button held through reset is seen as a fresh press afterwards.
  localparam logic             REL_RAW = ACTIVE_LOW;

  logic            sync1_q, sync2_q;
  logic            pressed;
  btn_state_e      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            hold_done_q, hold_done_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            hold_q, hold_d;

  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_UP: begin
        if (pressed) begin
          state_d  = ST_CONFIRM_DOWN;
          db_cnt_d = '0;
        end
      end
      ST_CONFIRM_DOWN: begin
        if (!pressed) begin
          state_d = ST_UP;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_DOWN;
          press_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ST_DOWN: begin
        if (!pressed) begin
          state_d  = ST_CONFIRM_UP;
          db_cnt_d = '0;
        end
      end
      ST_CONFIRM_UP: begin
        if (pressed) begin
          state_d = ST_DOWN;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_UP;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = ST_UP;
    endcase
  end

  // Hold timer runs while the debounced button is down, including through
  // CONFIRM_UP dropouts. It saturates at the last count; hold_done stops a
  // second pulse. An accepted release wins over a hold due on the same cycle.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    hold_d      = 1'b0;
    if (press_d || release_d) begin
      hold_cnt_d  = '0;
      hold_done_d = 1'b0;
    end else if (state_q == ST_DOWN || state_q == ST_CONFIRM_UP) begin
      if (hold_cnt_q == HD_LAST) begin
        if (!hold_done_q) begin
          hold_d      = 1'b1;
          hold_done_d = 1'b1;
        end
      end else begin
        hold_cnt_d = hold_cnt_q + HD_W'(1);
      end
    end
  end

  // Level follows the registered state, so it changes the cycle after the pulse.
  assign level_d = (state_q == ST_DOWN) || (state_q == ST_CONFIRM_UP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= REL_RAW;
      sync2_q     <= REL_RAW;
      state_q     <= ST_UP;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      hold_q      <= hold_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with press/release/hold event pulses.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 cycles after a clean raw edge; all outputs registered.
// Backpressure: none; each channel is independent and pulses are single-cycle.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   btn_i          raw asynchronous button inputs, one bit per channel
//   btn_level_o    debounced levels, 1 = pressed
//   btn_press_o    one-cycle pulses on accepted press
//   btn_release_o  one-cycle pulses on accepted release
//   btn_hold_o     one-cycle pulses HOLD_CYCLES after an accepted press
module btn_debounce
  import btn_pkg::*;
#(
  parameter int          NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic [NUM_BTN-1:0] btn_hold_o
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .btn_i     (btn_i[g]),
      .level_o   (btn_level_o[g]),
      .press_o   (btn_press_o[g]),
      .release_o (btn_release_o[g]),
      .hold_o    (btn_hold_o[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, three channels.
// A run-length/timestamp model predicts every output each cycle; directed
// scenarios additionally pin pulse timing to hand-computed cycle numbers.
module tb_btn_debounce;

  localparam int NB = 3;
  localparam int DB = 8;
  localparam int HC = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn   = '0;
  logic [NB-1:0] level, press, rel, hold;

  always #5 clk = ~clk;

  btn_debounce #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HC),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .btn_i         (btn),
    .btn_level_o   (level),
    .btn_press_o   (press),
    .btn_release_o (rel),
    .btn_hold_o    (hold)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;   // number of rising edges seen so far

  task automatic check_vec(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b required %b", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw input reaches the decision logic two edges late. A new level is
  // accepted once DB+1 consecutive samples disagree with the current one.
  // A hold is due exactly HC edges after an accepted press unless an
  // accepted release happened first.
  logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_acc = '0;
  logic [NB-1:0] e_level = '0, e_press = '0, e_rel = '0, e_hold = '0;
  int            m_run [NB] = '{default: 0};
  int            m_due [NB] = '{default: -1};
  logic          samp;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_acc = '0;
      e_level = '0; e_press = '0; e_rel = '0; e_hold = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i] = 0;
        m_due[i] = -1;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        samp       = m_d2[i];
        m_d2[i]    = m_d1[i];
        m_d1[i]    = btn[i];
        e_level[i] = m_acc[i];
        e_press[i] = 1'b0;
        e_rel[i]   = 1'b0;
        e_hold[i]  = 1'b0;
        if (samp != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_acc[i] = samp;
            m_run[i] = 0;
            if (samp) begin
              e_press[i] = 1'b1;
              m_due[i]   = cyc + HC;
            end else begin
              e_rel[i]   = 1'b1;
              m_due[i]   = -1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        if (m_due[i] == cyc) e_hold[i] = 1'b1;
      end
    end
  end

  // ---------------- event monitor ----------------
  int press_n [NB], press_at [NB], rel_n [NB], rel_at [NB];
  int hold_n  [NB], hold_at  [NB], rise_n [NB], rise_at [NB], fall_n [NB], fall_at [NB];
  logic [NB-1:0] prev_level = '0;

  task automatic clear_mon();
    for (int i = 0; i < NB; i++) begin
      press_n[i] = 0; press_at[i] = -1; rel_n[i]  = 0; rel_at[i]  = -1;
      hold_n[i]  = 0; hold_at[i]  = -1; rise_n[i] = 0; rise_at[i] = -1;
      fall_n[i]  = 0; fall_at[i]  = -1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check_vec("rst_level",   level, '0);
      check_vec("rst_press",   press, '0);
      check_vec("rst_release", rel,   '0);
      check_vec("rst_hold",    hold,  '0);
    end else begin
      check_vec("level",   level, e_level);
      check_vec("press",   press, e_press);
      check_vec("release", rel,   e_rel);
      check_vec("hold",    hold,  e_hold);
    end
    for (int i = 0; i < NB; i++) begin
      if (press[i] === 1'b1) begin press_n[i]++; press_at[i] = cyc; end
      if (rel[i]   === 1'b1) begin rel_n[i]++;   rel_at[i]   = cyc; end
      if (hold[i]  === 1'b1) begin hold_n[i]++;  hold_at[i]  = cyc; end
      if (level[i] === 1'b1 && prev_level[i] !== 1'b1) begin rise_n[i]++; rise_at[i] = cyc; end
      if (level[i] === 1'b0 && prev_level[i] === 1'b1) begin fall_n[i]++; fall_at[i] = cyc; end
    end
    prev_level = level;
  end

  // ---------------- directed stimulus ----------------
  // Inputs change 2 time units after a rising edge; the edge numbered cyc+1
  // is the first to sample them ("cycle 0" of each scenario).
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int c, c2;

  initial begin
    clear_mon();
    step(3);
    check_vec("reset_level_lit", level, 3'b000);
    check_vec("reset_press_lit", press, 3'b000);
    rst_n = 1'b1;
    step(5);

    // Clean press on ch0 held 40 cycles, then release.
    clear_mon();
    c = cyc;
    btn[0] = 1'b1;
    step(40);
    btn[0] = 1'b0;
    step(20);
    check_int("t1_press_at",   press_at[0], c + 11);
    check_int("t1_press_n",    press_n[0],  1);
    check_int("t1_level_rise", rise_at[0],  c + 12);
    check_int("t3_hold_at",    hold_at[0],  c + 43);
    check_int("t3_hold_n",     hold_n[0],   1);
    check_int("t3_release_at", rel_at[0],   c + 51);
    check_int("t3_level_fall", fall_at[0],  c + 52);

    // 5-cycle glitch on ch1 must be filtered.
    clear_mon();
    btn[1] = 1'b1;
    step(5);
    btn[1] = 1'b0;
    step(20);
    check_int("t2_press_n",  press_n[1], 0);
    check_int("t2_rise_n",   rise_n[1],  0);
    check_int("t2_release_n", rel_n[1],  0);

    // All three pressed together, released before the hold time.
    clear_mon();
    c = cyc;
    btn = 3'b111;
    step(12);
    btn = 3'b000;
    step(45);
    for (int i = 0; i < NB; i++) begin
      check_int($sformatf("t4_press_at%0d", i),   press_at[i], c + 11);
      check_int($sformatf("t4_release_at%0d", i), rel_at[i],   c + 23);
      check_int($sformatf("t4_hold_n%0d", i),     hold_n[i],   0);
    end

    // Reset 4 cycles into a press, button still held when reset lifts.
    clear_mon();
    btn[0] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    c2 = cyc;
    step(15);
    check_int("t5_press_n",  press_n[0],  1);
    check_int("t5_press_at", press_at[0], c2 + 11);
    btn[0] = 1'b0;
    step(15);

    // Reset in the middle of a hold: no hold, no release.
    clear_mon();
    btn[1] = 1'b1;
    step(30);
    rst_n  = 1'b0;
    btn[1] = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(40);
    check_int("t6_press_n",   press_n[1], 1);
    check_int("t6_hold_n",    hold_n[1],  0);
    check_int("t6_release_n", rel_n[1],   0);

    // 3-cycle dropout while down on ch2.
    clear_mon();
    c = cyc;
    btn[2] = 1'b1;
    step(20);
    btn[2] = 1'b0;
    step(3);
    btn[2] = 1'b1;
    step(30);
    check_int("t7_release_n", rel_n[2],   0);
    check_int("t7_fall_n",    fall_n[2],  0);
    check_int("t7_hold_at",   hold_at[2], c + 43);
    check_int("t7_hold_n",    hold_n[2],  1);
    btn[2] = 1'b0;
    step(20);
    check_int("t7_release_after", rel_n[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
